// File: rtl/ret_addr_stack.sv
// Return-address stack: circular buffer of predicted return targets for fetch.
// Optional macro RAS_BYPASS_EN forwards a same-cycle push straight to top_addr.
module ret_addr_stack #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int INC    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          pc_in,
    output logic [ADDR_W-1:0]          top_addr,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf,
    output logic                       unf
);

    localparam int WP_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [WP_W-1:0] LAST = WP_W'(DEPTH - 1);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [WP_W-1:0]   wp;
    logic [WP_W-1:0]   wpInc;
    logic [WP_W-1:0]   wpDec;
    logic [ADDR_W-1:0] retAddr;
    logic              nonEmpty;

    // Explicit wrap keeps the pointer legal when DEPTH is not a power of two.
    always_comb begin
        wpInc    = (wp == LAST) ? '0 : wp + WP_W'(1);
        wpDec    = (wp == '0) ? LAST : wp - WP_W'(1);
        retAddr  = pc_in + INC_W;
        nonEmpty = (count != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            unf <= 1'b0;
            if (flush) begin
                wp    <= '0;
                count <= '0;
            end else if (push && pop && nonEmpty) begin
                mem[wpDec] <= retAddr;
            end else if (push) begin
                mem[wp] <= retAddr;
                wp      <= wpInc;
                if (count == FULL) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else if (pop) begin
                if (nonEmpty) begin
                    wp    <= wpDec;
                    count <= count - CNT_W'(1);
                end else begin
                    unf <= 1'b1;
                end
            end
        end
    end

`ifdef RAS_BYPASS_EN
    // A call followed immediately by a return must see the address being pushed.
    always_comb begin
        if (push && !flush) begin
            top_addr = retAddr;
            valid    = 1'b1;
        end else begin
            top_addr = nonEmpty ? mem[wpDec] : '0;
            valid    = nonEmpty;
        end
    end
`else
    always_comb begin
        top_addr = nonEmpty ? mem[wpDec] : '0;
        valid    = nonEmpty;
    end
`endif

endmodule

// File: tb/tb_ret_addr_stack.sv
// Self-checking bench for ret_addr_stack: directed vector table, overflow and
// reset sequences, then random traffic against a queue-based reference model.
module tb_ret_addr_stack;

    logic        clk;
    logic        rst;
    logic        push;
    logic        pop;
    logic        flush;
    logic [31:0] pcIn;
    logic [31:0] topAddr;
    logic        valid;
    logic [3:0]  count;
    logic        ovf;
    logic        unf;

    int nVec = 0;
    int nErr = 0;

    ret_addr_stack #(.ADDR_W(32), .DEPTH(8), .INC(1)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
        .pc_in(pcIn), .top_addr(topAddr), .valid(valid), .count(count),
        .ovf(ovf), .unf(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pu;
        logic        po;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] eTop;
        logic        eValid;
        logic [3:0]  eCnt;
        logic        eOvf;
        logic        eUnf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] eTop, input logic eValid,
                         input logic [3:0] eCnt, input logic eOvf, input logic eUnf);
        nVec++;
        if (topAddr !== eTop) begin
            nErr++;
            $display("FAIL %s top_addr: got %h want %h", name, topAddr, eTop);
        end
        if (valid !== eValid) begin
            nErr++;
            $display("FAIL %s valid: got %b want %b", name, valid, eValid);
        end
        if (count !== eCnt) begin
            nErr++;
            $display("FAIL %s count: got %0d want %0d", name, count, eCnt);
        end
        if (ovf !== eOvf) begin
            nErr++;
            $display("FAIL %s ovf: got %b want %b", name, ovf, eOvf);
        end
        if (unf !== eUnf) begin
            nErr++;
            $display("FAIL %s unf: got %b want %b", name, unf, eUnf);
        end
    endtask

    // Present inputs for one edge, then return them to idle before sampling.
    task automatic stepOnce(input logic pu, input logic po, input logic fl, input logic [31:0] pc);
        push  = pu;
        pop   = po;
        flush = fl;
        pcIn  = pc;
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        #1;
    endtask

    vec_t vecs[$];
    logic [31:0] model[$];

    initial begin
        logic [31:0] prevTop;
        logic        mOvf;
        logic        mUnf;
        logic        rPu;
        logic        rPo;
        logic        rFl;
        logic [31:0] rPc;
        logic [31:0] val;

        rst = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        flush = 1'b0;
        pcIn = '0;
        #2;
        check("reset", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        vecs.push_back('{1, 0, 0, 32'h100,      32'h101, 1, 4'd1, 0, 0});
        vecs.push_back('{1, 0, 0, 32'h200,      32'h201, 1, 4'd2, 0, 0});
        vecs.push_back('{1, 0, 0, 32'h300,      32'h301, 1, 4'd3, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h201, 1, 4'd2, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h101, 1, 4'd1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h0,   0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h0,   0, 4'd0, 0, 1});
        vecs.push_back('{0, 0, 0, 32'h0,        32'h0,   0, 4'd0, 0, 0});
        vecs.push_back('{1, 0, 0, 32'h40,       32'h41,  1, 4'd1, 0, 0});
        vecs.push_back('{1, 1, 0, 32'h80,       32'h81,  1, 4'd1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h0,   0, 4'd0, 0, 0});
        vecs.push_back('{1, 1, 0, 32'h10,       32'h11,  1, 4'd1, 0, 0});
        vecs.push_back('{1, 0, 1, 32'h55,       32'h0,   0, 4'd0, 0, 0});
        vecs.push_back('{1, 0, 0, 32'hFFFFFFFF, 32'h0,   1, 4'd1, 0, 0});
        vecs.push_back('{0, 0, 1, 32'h0,        32'h0,   0, 4'd0, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            stepOnce(vecs[i].pu, vecs[i].po, vecs[i].fl, vecs[i].pc);
            check($sformatf("vec%0d", i), vecs[i].eTop, vecs[i].eValid, vecs[i].eCnt,
                  vecs[i].eOvf, vecs[i].eUnf);
        end

        // Nine pushes into an 8-deep stack: the ninth drops the oldest entry.
        for (int k = 1; k <= 9; k++) begin
            stepOnce(1'b1, 1'b0, 1'b0, 32'(k));
            check($sformatf("fill%0d", k), 32'(k + 1), 1'b1, (k > 8) ? 4'd8 : 4'(k),
                  k == 9, 1'b0);
        end
        stepOnce(1'b0, 1'b0, 1'b0, 32'h0);
        check("ovf_drop", 32'd10, 1'b1, 4'd8, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            stepOnce(1'b0, 1'b1, 1'b0, 32'h0);
            check($sformatf("drain%0d", k), (k == 8) ? 32'h0 : 32'(10 - k), k != 8,
                  4'(8 - k), 1'b0, 1'b0);
        end

        // Same-cycle view of a push before its edge.
        stepOnce(1'b1, 1'b0, 1'b0, 32'h20);
        prevTop = topAddr;
        push = 1'b1;
        pcIn = 32'h500;
        #1;
`ifdef RAS_BYPASS_EN
        check("bypass", 32'h501, 1'b1, 4'd1, 1'b0, 1'b0);
`else
        check("no_bypass", prevTop, 1'b1, 4'd1, 1'b0, 1'b0);
`endif
        @(posedge clk);
        #1;
        push = 1'b0;
        #1;
        check("after_bypass", 32'h501, 1'b1, 4'd2, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle, away from any rising edge.
        stepOnce(1'b1, 1'b0, 1'b0, 32'h700);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        model.delete();
        for (int n = 0; n < 600; n++) begin
            rPu = ($urandom_range(0, 99) < 50);
            rPo = ($urandom_range(0, 99) < 40);
            rFl = ($urandom_range(0, 99) < 3);
            rPc = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : $urandom;
            val = rPc + 32'd1;
            mOvf = 1'b0;
            mUnf = 1'b0;
            if (rFl) begin
                model.delete();
            end else if (rPu && rPo && model.size() > 0) begin
                model[model.size() - 1] = val;
            end else if (rPu) begin
                if (model.size() == 8) begin
                    void'(model.pop_front());
                    mOvf = 1'b1;
                end
                model.push_back(val);
            end else if (rPo) begin
                if (model.size() > 0) void'(model.pop_back());
                else mUnf = 1'b1;
            end
            stepOnce(rPu, rPo, rFl, rPc);
            check($sformatf("rand%0d", n), (model.size() > 0) ? model[model.size() - 1] : 32'h0,
                  model.size() > 0, 4'(model.size()), mOvf, mUnf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/ret_addr_stack.md
# ret_addr_stack

- Parametrised return-address stack (RAS) for the pipeline's fetch stage.
- On a call, it computes the return address as `pc_in + INC` and pushes it. On a return, it pops the entry.
- It always presents the top entry as the predicted return target.
- It generalises the single return-address increment with configurable address width, step, depth and overflow/underflow tracking.

## Interface
Parameters:
- ADDR_W, 32, address width in bits.
- DEPTH, 8, number of stack entries; legal range 2..64; need not be a power of two.
- INC, 1, return-address step added to `pc_in`; 1 because the design is word-addressed.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- push  input  1  call detected; push `pc_in + INC`.
- pop  input  1  return detected; pop top entry.
- flush  input  1  synchronous clear of the stack; used on pipeline redirect.
- pc_in  input  ADDR_W  address of the call instruction.
- top_addr  output  ADDR_W  current top entry; 0 when empty.
- valid  output  1  stack non-empty.
- count  output  $clog2(DEPTH+1)  number of live entries.
- ovf  output  1  one-cycle pulse: the push overwrote the oldest entry.
- unf  output  1  one-cycle pulse: pop was attempted on an empty stack.

## Operation
Storage and reset:
- Circular buffer `mem[0..DEPTH-1]`, write pointer `wp` (next free slot) and `count`.
- Top entry is `mem[(wp-1) mod DEPTH]`.
- Reset clears all entries, `wp`, `count`, `ovf` and `unf` to 0.
- After reset: `top_addr`=0, `valid`=0, `count`=0, `ovf`=0, `unf`=0.

Arithmetic:
- Return value is `(pc_in + INC) mod 2^ADDR_W`; overflow wraps silently, e.g. 0xFFFFFFFF+1 → 0.
- `wp` wraps explicitly from DEPTH-1 to 0 on increment, and from 0 to DEPTH-1 on decrement.

Per-cycle action, in priority order:
- flush=1: `wp`←0, `count`←0. Push and pop are ignored that cycle; `ovf` and `unf` are 0.
- push=1, pop=1, count>0: top entry is replaced by the new value; `wp` and `count` are unchanged.
- push=1, pop=1, count=0: treated as a plain push; no `unf`.
- push only, count<DEPTH: `mem[wp]`←value, `wp`++, `count`++.
- push only, count=DEPTH: `mem[wp]`←value, overwriting the oldest entry; `wp`++, `count` stays DEPTH, `ovf`=1 next cycle.
- pop only, count>0: `wp`--, `count`--; the popped entry is not cleared.
- pop only, count=0: no state change, `unf`=1 next cycle.
- Neither push nor pop: hold.

Output derivation:
- `valid` = (count != 0).
- `top_addr` = top entry when valid, else 0.
- No FSM beyond pointer/count state.

## Timing
- Push/pop effects are visible on `top_addr`, `count` and `valid` after the same rising edge; latency 1 cycle.
- `ovf` and `unf` are registered and high for exactly one cycle following the offending edge.
- rst is asynchronous: outputs go to reset values immediately. A push/pop presented during or at the release of reset is lost.
- Inputs are sampled only at the rising edge; there is no handshake and no back-pressure. The stack always accepts.

## Configuration
- Macro `RAS_BYPASS_EN`.
- Defined: `top_addr` forwards the pending value combinationally.
  - When push=1 and flush=0 in the current cycle, `top_addr` = `pc_in + INC` before the edge, and `valid`=1.
  - This allows a call immediately followed by a return to predict correctly.
- Undefined: `top_addr` and `valid` depend only on registered state, with 1-cycle latency as above.
- Counter, `ovf` and `unf` behaviour are identical in both builds.

## Test plan
- Reset, then push `pc_in`=0x100, 0x200, 0x300 → `top_addr`=0x301, `count`=3. Three pops → tops 0x201, 0x101, then 0; `valid`=0.
- DEPTH=8: push 9 times with `pc_in`=1..9 → `ovf` high one cycle after the 9th push, `count`=8, `top_addr`=10. Pop 8 times → last valid top is 3.
- Empty stack: pop → `unf`=1 for one cycle, `count` stays 0, `top_addr`=0.
- Push 0x40, then push+pop together with `pc_in`=0x80 → `count`=1, `top_addr`=0x81. Then push+pop on an empty stack → `count`=1, no `unf`.
- Push 0xFFFFFFFF → `top_addr`=0. Flush with push=1 → `count`=0, `ovf`=0. Assert rst mid-sequence → all outputs 0 without waiting for a clock edge.
- With `RAS_BYPASS_EN` defined: push `pc_in`=0x500 → `top_addr`=0x501 in the same cycle, before the edge.
